// File: rtl/cached_storage_controller.sv
// cached_storage_controller: scratchpad plus cached SPI-flash (cmd 0x03) memory port with programmer pass-through
module cached_storage_controller #(
  parameter int MEM_W = 32,
  parameter int SPM_WORDS = 2048,
  parameter logic [31:0] SPM_BASE = 32'h0000_0000,
  parameter logic [31:0] EXT_BASE = 32'h0100_0000,
  parameter int CACHE_LINES = 16,
  parameter int SCK_DIV = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [31:0]        req_addr,
  input  logic [MEM_W/8-1:0] req_be,
  input  logic [MEM_W-1:0]   req_wdata,
  output logic               resp_valid,
  output logic [MEM_W-1:0]   resp_rdata,
  output logic               resp_err,
  input  logic               prog_mode,
  output logic               flash_cs_n,
  output logic               flash_sck,
  output logic               flash_mosi,
  input  logic               flash_miso,
  input  logic               prog_cs_n,
  input  logic               prog_sck,
  input  logic               prog_mosi,
  output logic               prog_miso
);
  localparam int BW = MEM_W / 8;
  localparam int OB = $clog2(BW);
  localparam int SA = $clog2(SPM_WORDS);
  localparam int IW = $clog2(CACHE_LINES);
  localparam int TW = 24 - OB - IW;
  localparam int NB = 32 + MEM_W;
  localparam int CW = $clog2(NB + 1);
  localparam int DW = SCK_DIV > 1 ? $clog2(SCK_DIV) : 1;
  localparam logic [31:0] SPM_MASK = ~(32'(SPM_WORDS * BW) - 32'd1);
  typedef enum logic [2:0] {IDLE, SPM_RESP, HIT_RESP, SPI_XFER, PROG} state_t;
  state_t state_q, state_d;
  logic [MEM_W-1:0] spm [SPM_WORDS];
  logic [MEM_W-1:0] line_data [CACHE_LINES];
  logic [TW-1:0] line_tag [CACHE_LINES];
  logic [CACHE_LINES-1:0] valid_q, valid_d;
  logic rv_q, rv_d, err_q, err_d, cs_n_q, cs_n_d, sck_q, sck_d;
  logic [MEM_W-1:0] rdata_q, rdata_d, rx_q, rx_d, rx_word;
  logic [31:0] tx_q, tx_d;
  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] lidx_q, lidx_d, req_idx;
  logic [TW-1:0] ltag_q, ltag_d, req_tag;
  logic [SA-1:0] spm_idx;
  logic [23:0] req_off;
  logic accept, is_spm, is_ext, hit, spm_we, fill, tick;
  assign req_ready = state_q == IDLE && !prog_mode;
  assign accept = req_valid && req_ready && !rst;
  assign is_spm = (req_addr & SPM_MASK) == SPM_BASE;
  assign is_ext = req_addr[31:24] == EXT_BASE[31:24];
  assign req_off = req_addr[23:0] & ~24'(BW - 1);
  assign spm_idx = req_addr[OB +: SA];
  assign req_idx = req_off[OB +: IW];
  assign req_tag = req_off[23 -: TW];
  assign hit = valid_q[req_idx] && line_tag[req_idx] == req_tag;
  assign spm_we = accept && is_spm && req_we;
  assign tick = div_q == DW'(SCK_DIV - 1);
  assign fill = state_q == SPI_XFER && tick && sck_q && cnt_q == CW'(NB - 1);
  assign resp_valid = rv_q;
  assign resp_rdata = rdata_q;
  assign resp_err = err_q;
  assign flash_cs_n = state_q == PROG ? prog_cs_n : cs_n_q;
  assign flash_sck = state_q == PROG ? prog_sck : sck_q;
  assign flash_mosi = state_q == PROG ? prog_mosi : tx_q[31];
  assign prog_miso = state_q == PROG && flash_miso;
  always_comb begin
    rx_word = '0;
    for (int i = 0; i < BW; i++) rx_word[8*i +: 8] = rx_q[MEM_W-8-8*i +: 8];
  end
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    rv_d = 1'b0;
    err_d = 1'b0;
    rdata_d = '0;
    cs_n_d = cs_n_q;
    sck_d = sck_q;
    tx_d = tx_q;
    rx_d = rx_q;
    div_d = div_q;
    cnt_d = cnt_q;
    lidx_d = lidx_q;
    ltag_d = ltag_q;
    case (state_q)
      IDLE: begin
        if (prog_mode) state_d = PROG;
        else if (req_valid) begin
          if (is_spm) begin
            state_d = SPM_RESP;
            rv_d = 1'b1;
            rdata_d = req_we ? '0 : spm[spm_idx];
          end else if (!is_ext || req_we) begin
            state_d = SPM_RESP;
            rv_d = 1'b1;
            err_d = 1'b1;
          end else if (hit) begin
            state_d = HIT_RESP;
            rv_d = 1'b1;
            rdata_d = line_data[req_idx];
          end else begin
            state_d = SPI_XFER;
            cs_n_d = 1'b0;
            sck_d = 1'b0;
            tx_d = {8'h03, req_off};
            div_d = '0;
            cnt_d = '0;
            lidx_d = req_idx;
            ltag_d = req_tag;
          end
        end
      end
      SPM_RESP, HIT_RESP: state_d = IDLE;
      SPI_XFER: begin
        div_d = tick ? '0 : div_q + 1'b1;
        if (tick) begin
          sck_d = !sck_q;
          // rising edge samples MISO; the 32 command-phase samples fall off the top
          if (!sck_q) rx_d = {rx_q[MEM_W-2:0], flash_miso};
          else begin
            tx_d = tx_q << 1;
            cnt_d = cnt_q + 1'b1;
            if (fill) begin
              cs_n_d = 1'b1;
              rv_d = 1'b1;
              rdata_d = rx_word;
              valid_d[lidx_q] = 1'b1;
              state_d = IDLE;
            end
          end
        end
      end
      PROG: begin
        if (!prog_mode) begin
          state_d = IDLE;
          valid_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      rv_q <= 1'b0;
      err_q <= 1'b0;
      rdata_q <= '0;
      cs_n_q <= 1'b1;
      sck_q <= 1'b0;
      tx_q <= '0;
      rx_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
      lidx_q <= '0;
      ltag_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      rv_q <= rv_d;
      err_q <= err_d;
      rdata_q <= rdata_d;
      cs_n_q <= cs_n_d;
      sck_q <= sck_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
      lidx_q <= lidx_d;
      ltag_q <= ltag_d;
    end
  end
  always_ff @(posedge clk) begin
    if (spm_we)
      for (int i = 0; i < BW; i++)
        if (req_be[i]) spm[spm_idx][8*i +: 8] <= req_wdata[8*i +: 8];
    if (fill && !rst) begin
      line_data[lidx_q] <= rx_word;
      line_tag[lidx_q] <= ltag_q;
    end
  end
endmodule
